// File: rtl/video_pkg.sv
// ============================================================================
// Module      : video_pkg
// Description : Shared state encoding and default geometry for line capture.
// Revision    : 1.0
// ============================================================================
`default_nettype none

package video_pkg;

    localparam int unsigned ADDR_WIDTH_DEF = 11;
    localparam int unsigned HACTIVE_DEF    = 640;
    localparam int unsigned VACTIVE_DEF    = 480;

    // A pixel strictly darker than the threshold is a pupil candidate
    localparam bit DARK_BELOW_THRESHOLD = 1'b1;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_WAIT_LINE = 3'd1,
        ST_ACTIVE    = 3'd2,
        ST_WRITE     = 3'd3,
        ST_DONE      = 3'd4
    } state_t;

endpackage

`default_nettype wire

// File: rtl/video_line_capture_delay.sv
// ============================================================================
// Module      : video_line_capture_delay
// Description : One-cycle register stage with asynchronous active-low reset.
// Revision    : 1.0
// ============================================================================
`default_nettype none

module video_line_capture_delay #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] i_d,
    output logic [WIDTH-1:0] o_q
);

    logic [WIDTH-1:0] data_q;
    logic [WIDTH-1:0] data_d;

    always_comb data_d = i_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) data_q <= '0;
        else        data_q <= data_d;
    end

    assign o_q = data_q;

endmodule

`default_nettype wire

// File: rtl/video_line_capture_sync_edge_detect.sv
// ============================================================================
// Module      : sync_edge_detect
// Description : Registers a 1-bit input and flags rising/falling edges of
//               the registered level.
// Revision    : 1.0
// ============================================================================
`default_nettype none

module sync_edge_detect (
    input  logic clk,
    input  logic rst_n,
    input  logic i_sig,
    output logic o_level,
    output logic o_rise,
    output logic o_fall
);

    logic sig_q;
    logic sig_d;
    logic prev_q;
    logic prev_d;

    always_comb begin
        sig_d  = i_sig;
        prev_d = sig_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sig_q  <= 1'b0;
            prev_q <= 1'b0;
        end else begin
            sig_q  <= sig_d;
            prev_q <= prev_d;
        end
    end

    assign o_level = sig_q;
    assign o_rise  = sig_q & ~prev_q;
    assign o_fall  = ~sig_q & prev_q;

endmodule

`default_nettype wire

// File: rtl/video_line_capture.sv
// ============================================================================
// Module      : video_line_capture
// Description : Thresholds camera lines into 1-bit-per-pixel words, writes them
//               to line memory and reports per-frame dark statistics.
// Revision    : 1.0
// ============================================================================
`default_nettype none

module video_line_capture
    import video_pkg::*;
#(
    parameter int ADDR_WIDTH  = ADDR_WIDTH_DEF,
    parameter int HACTIVE     = HACTIVE_DEF,
    parameter int VACTIVE     = VACTIVE_DEF,
    parameter int PIXEL_WIDTH = 8,
    parameter int COUNT_WIDTH = 20
) (
    input  logic                   VCLK,
    input  logic                   RST_N,
    input  logic                   iVSYNC,
    input  logic                   iHSYNC,
    input  logic                   iDE,
    input  logic [PIXEL_WIDTH-1:0] iPIXEL,
    input  logic [PIXEL_WIDTH-1:0] iTHRESHOLD,
    input  logic                   iCAPTURE_EN,
    output logic                   oLINE_WE,
    output logic [ADDR_WIDTH-1:0]  oLINE_ADDR,
    output logic [HACTIVE-1:0]     oLINE_DATA,
    output logic [ADDR_WIDTH-1:0]  oH_ADDR,
    output logic [ADDR_WIDTH-1:0]  oV_ADDR,
    output logic                   oFRAME_DONE,
    output logic                   oFRAME_ERR,
    output logic                   oOVERRUN,
    output logic [COUNT_WIDTH-1:0] oDARK_COUNT
);

    localparam logic [ADDR_WIDTH-1:0] c_hactive = ADDR_WIDTH'(HACTIVE);
    localparam logic [ADDR_WIDTH-1:0] c_vlast   = ADDR_WIDTH'(VACTIVE - 1);

    state_t                 state_q, state_d;
    logic [ADDR_WIDTH-1:0]  h_q, h_d;
    logic [ADDR_WIDTH-1:0]  v_q, v_d;
    logic [HACTIVE-1:0]     line_q, line_d;
    logic [COUNT_WIDTH-1:0] acc_q, acc_d;
    logic [COUNT_WIDTH-1:0] dark_count_q, dark_count_d;
    logic                   overrun_q, overrun_d;
    logic                   frame_err_q, frame_err_d;

    logic                   w_vs_rise, w_vs_fall, w_vs_level;
    logic                   w_de_rise, w_de_fall, w_de_level;
    logic [PIXEL_WIDTH-1:0] w_pix, w_thr;
    logic                   w_cap;
    logic                   w_dark;
    logic                   w_accept;
    logic                   w_restart;
    logic [ADDR_WIDTH-1:0]  w_idx;
    logic                   w_unused;

    sync_edge_detect u_vsync_edge (
        .clk     (VCLK),
        .rst_n   (RST_N),
        .i_sig   (iVSYNC),
        .o_level (w_vs_level),
        .o_rise  (w_vs_rise),
        .o_fall  (w_vs_fall)
    );

    sync_edge_detect u_de_edge (
        .clk     (VCLK),
        .rst_n   (RST_N),
        .i_sig   (iDE),
        .o_level (w_de_level),
        .o_rise  (w_de_rise),
        .o_fall  (w_de_fall)
    );

    video_line_capture_delay #(
        .WIDTH (2 * PIXEL_WIDTH + 1)
    ) u_in_stage (
        .clk   (VCLK),
        .rst_n (RST_N),
        .i_d   ({iCAPTURE_EN, iTHRESHOLD, iPIXEL}),
        .o_q   ({w_cap, w_thr, w_pix})
    );

    assign w_dark   = DARK_BELOW_THRESHOLD ? (w_pix < w_thr) : (w_pix >= w_thr);
    assign w_unused = ^{iHSYNC, w_vs_fall, w_vs_level};

    always_ff @(posedge VCLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q      <= ST_IDLE;
            h_q          <= '0;
            v_q          <= '0;
            line_q       <= '0;
            acc_q        <= '0;
            dark_count_q <= '0;
            overrun_q    <= 1'b0;
            frame_err_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            h_q          <= h_d;
            v_q          <= v_d;
            line_q       <= line_d;
            acc_q        <= acc_d;
            dark_count_q <= dark_count_d;
            overrun_q    <= overrun_d;
            frame_err_q  <= frame_err_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        h_d          = h_q;
        v_d          = v_q;
        line_d       = line_q;
        acc_d        = acc_q;
        dark_count_d = dark_count_q;
        overrun_d    = overrun_q;
        frame_err_d  = 1'b0;
        w_accept     = 1'b0;
        w_restart    = 1'b0;
        w_idx        = '0;

        case (state_q)
            ST_IDLE: begin
                if (w_vs_rise) w_restart = 1'b1;
            end
            ST_WAIT_LINE: begin
                if (w_vs_rise) begin
                    frame_err_d = 1'b1;
                    w_restart   = 1'b1;
                end else if (w_de_rise) begin
                    // The rising-edge cycle already carries pixel 0
                    state_d  = ST_ACTIVE;
                    line_d   = '0;
                    w_accept = 1'b1;
                end
            end
            ST_ACTIVE: begin
                if (w_vs_rise) begin
                    frame_err_d = 1'b1;
                    w_restart   = 1'b1;
                end else begin
                    if (w_de_level) begin
                        if (h_q < c_hactive) begin
                            w_accept = 1'b1;
                            w_idx    = h_q;
                        end else begin
                            overrun_d = 1'b1;
                        end
                    end
                    if (w_de_fall) state_d = ST_WRITE;
                end
            end
            ST_WRITE: begin
                v_d = v_q + 1'b1;
                if (w_vs_rise) begin
                    frame_err_d = 1'b1;
                    w_restart   = 1'b1;
                end else if (v_q == c_vlast) begin
                    state_d = ST_DONE;
                end else begin
                    state_d = ST_WAIT_LINE;
                end
            end
            ST_DONE: begin
                dark_count_d = acc_q;
                h_d          = '0;
                v_d          = '0;
                state_d      = ST_IDLE;
                if (w_vs_rise) w_restart = 1'b1;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (w_accept) begin
            for (int i = 0; i < HACTIVE; i++) begin
                if (w_idx == ADDR_WIDTH'(i)) line_d[i] = w_dark;
            end
            h_d = w_idx + 1'b1;
            if (w_dark && (acc_q != '1)) acc_d = acc_q + 1'b1;
        end

        // Any VSYNC edge outside DONE opens a new frame if capture is armed
        if (w_restart) begin
            h_d = '0;
            v_d = '0;
            if (w_cap) begin
                state_d   = ST_WAIT_LINE;
                acc_d     = '0;
                overrun_d = 1'b0;
            end else begin
                state_d = ST_IDLE;
            end
        end
    end

    assign oLINE_WE    = (state_q == ST_WRITE);
    assign oLINE_ADDR  = (state_q == ST_WRITE) ? v_q : '0;
    assign oLINE_DATA  = line_q;
    assign oH_ADDR     = (state_q == ST_IDLE) ? '0 : h_q;
    assign oV_ADDR     = (state_q == ST_IDLE) ? '0 : v_q;
    assign oFRAME_DONE = (state_q == ST_DONE);
    assign oFRAME_ERR  = frame_err_q;
    assign oOVERRUN    = overrun_q;
    assign oDARK_COUNT = dark_count_q;

endmodule

`default_nettype wire

// File: tb/tb_video_line_capture.sv
// ============================================================================
// Module      : tb_video_line_capture
// Description : Directed self-checking bench for video_line_capture (4x2 frame).
// Revision    : 1.0
// ============================================================================
`default_nettype none

module tb_video_line_capture;

    logic        VCLK = 1'b0;
    logic        RST_N;
    logic        iVSYNC, iHSYNC, iDE, iCAPTURE_EN;
    logic [7:0]  iPIXEL, iTHRESHOLD;
    logic        oLINE_WE, oFRAME_DONE, oFRAME_ERR, oOVERRUN;
    logic [10:0] oLINE_ADDR, oH_ADDR, oV_ADDR;
    logic [3:0]  oLINE_DATA;
    logic [19:0] oDARK_COUNT;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    int          we_cnt = 0, done_cnt = 0, err_cnt = 0;
    int          done_cyc = 0, err_cyc = 0;
    logic [10:0] we_addr [64];
    logic [3:0]  we_data [64];
    int          we_cyc  [64];

    video_line_capture #(
        .ADDR_WIDTH  (11),
        .HACTIVE     (4),
        .VACTIVE     (2),
        .PIXEL_WIDTH (8),
        .COUNT_WIDTH (20)
    ) dut (
        .VCLK        (VCLK),
        .RST_N       (RST_N),
        .iVSYNC      (iVSYNC),
        .iHSYNC      (iHSYNC),
        .iDE         (iDE),
        .iPIXEL      (iPIXEL),
        .iTHRESHOLD  (iTHRESHOLD),
        .iCAPTURE_EN (iCAPTURE_EN),
        .oLINE_WE    (oLINE_WE),
        .oLINE_ADDR  (oLINE_ADDR),
        .oLINE_DATA  (oLINE_DATA),
        .oH_ADDR     (oH_ADDR),
        .oV_ADDR     (oV_ADDR),
        .oFRAME_DONE (oFRAME_DONE),
        .oFRAME_ERR  (oFRAME_ERR),
        .oOVERRUN    (oOVERRUN),
        .oDARK_COUNT (oDARK_COUNT)
    );

    always #5 VCLK = ~VCLK;

    always @(posedge VCLK) cyc <= cyc + 1;

    always @(negedge VCLK) begin
        if (oLINE_WE) begin
            we_addr[we_cnt % 64] = oLINE_ADDR;
            we_data[we_cnt % 64] = oLINE_DATA;
            we_cyc[we_cnt % 64]  = cyc;
            we_cnt = we_cnt + 1;
        end
        if (oFRAME_DONE) begin
            done_cyc = cyc;
            done_cnt = done_cnt + 1;
        end
        if (oFRAME_ERR) begin
            err_cyc = cyc;
            err_cnt = err_cnt + 1;
        end
    end

    task automatic check_value(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge VCLK);
        #1;
    endtask

    task automatic vsync_pulse(output int vc);
        iVSYNC = 1'b1;
        vc     = cyc;
        tick();
        tick();
        iVSYNC = 1'b0;
    endtask

    // Pixel i is byte i of px; returns the cycle where DE is first driven low
    task automatic send_line(input logic [63:0] px, input int n, output int low_cyc);
        for (int i = 0; i < n; i++) begin
            iDE    = 1'b1;
            iPIXEL = px[8*i +: 8];
            tick();
        end
        iDE     = 1'b0;
        iPIXEL  = 8'h00;
        low_cyc = cyc;
        repeat (3) tick();
    endtask

    initial begin
        int vc, l0, l1, wb, db, eb;
        RST_N = 1'b0; iVSYNC = 1'b0; iHSYNC = 1'b0; iDE = 1'b0;
        iPIXEL = 8'h00; iTHRESHOLD = 8'h80; iCAPTURE_EN = 1'b0;
        repeat (3) tick();
        check_value("rst_we",    oLINE_WE,    0);
        check_value("rst_done",  oFRAME_DONE, 0);
        check_value("rst_dark",  oDARK_COUNT, 0);
        check_value("rst_data",  oLINE_DATA,  0);
        check_value("rst_haddr", oH_ADDR,     0);
        RST_N = 1'b1;
        repeat (2) tick();

        // Basic 4x2 frame
        iCAPTURE_EN = 1'b1;
        tick();
        wb = we_cnt; db = done_cnt; eb = err_cnt;
        vsync_pulse(vc);
        repeat (3) tick();
        send_line(64'h80_7F_F0_10, 4, l0);
        check_value("vaddr_after_line0", oV_ADDR, 1);
        send_line(64'h80_7F_F0_10, 4, l1);
        repeat (4) tick();
        check_value("t1_we_count", we_cnt - wb, 2);
        check_value("t1_addr0",    we_addr[wb], 0);
        check_value("t1_data0",    we_data[wb], 4'b0101);
        check_value("t1_addr1",    we_addr[wb+1], 1);
        check_value("t1_data1",    we_data[wb+1], 4'b0101);
        check_value("t1_we_latency", we_cyc[wb], l0 + 2);
        check_value("t1_done_count", done_cnt - db, 1);
        check_value("t1_done_cycle", done_cyc, we_cyc[wb+1] + 1);
        check_value("t1_dark",     oDARK_COUNT, 4);
        check_value("t1_no_err",   err_cnt - eb, 0);
        check_value("t1_vaddr_idle", oV_ADDR, 0);

        // Capture disarmed: frame ignored
        iCAPTURE_EN = 1'b0;
        tick();
        wb = we_cnt; db = done_cnt;
        vsync_pulse(vc);
        repeat (3) tick();
        send_line(64'h00_00_00_00, 4, l0);
        send_line(64'h00_00_00_00, 4, l1);
        repeat (4) tick();
        check_value("t2_no_we",   we_cnt - wb, 0);
        check_value("t2_no_done", done_cnt - db, 0);
        check_value("t2_dark",    oDARK_COUNT, 4);

        // Overrun line then short line
        iCAPTURE_EN = 1'b1;
        tick();
        wb = we_cnt; db = done_cnt;
        vsync_pulse(vc);
        repeat (3) tick();
        send_line(64'h00_00_00_00_00_00, 6, l0);
        check_value("t3_long_data", we_data[wb], 4'b1111);
        check_value("t3_overrun",   oOVERRUN, 1);
        send_line(64'h00_00, 2, l1);
        repeat (4) tick();
        check_value("t3_short_data", we_data[wb+1], 4'b0011);
        check_value("t3_done",       done_cnt - db, 1);
        check_value("t3_dark",       oDARK_COUNT, 6);
        check_value("t3_overrun_sticky", oOVERRUN, 1);
        vsync_pulse(vc);
        tick();
        check_value("t3_overrun_clear", oOVERRUN, 0);

        // Early VSYNC after line 0, then a full frame
        wb = we_cnt; db = done_cnt; eb = err_cnt;
        send_line(64'h80_7F_F0_10, 4, l0);
        check_value("t4_line0_addr", we_addr[wb], 0);
        vsync_pulse(vc);
        repeat (3) tick();
        check_value("t4_err_count", err_cnt - eb, 1);
        check_value("t4_err_cycle", err_cyc, vc + 2);
        check_value("t4_dark_kept", oDARK_COUNT, 6);
        check_value("t4_no_done",   done_cnt - db, 0);
        send_line(64'hFF_00_00_FF, 4, l0);
        send_line(64'hFF_00_00_00, 4, l1);
        repeat (4) tick();
        check_value("t4_we_count", we_cnt - wb, 3);
        check_value("t4_addr_restart", we_addr[wb+1], 0);
        check_value("t4_data_a", we_data[wb+1], 4'b0110);
        check_value("t4_addr_b", we_addr[wb+2], 1);
        check_value("t4_data_b", we_data[wb+2], 4'b0111);
        check_value("t4_done",   done_cnt - db, 1);
        check_value("t4_dark",   oDARK_COUNT, 5);

        // Reset in the middle of an active line
        vsync_pulse(vc);
        repeat (3) tick();
        iDE = 1'b1; iPIXEL = 8'h00;
        tick();
        tick();
        check_value("t5_h_before_rst",    oH_ADDR, 1);
        check_value("t5_data_before_rst", oLINE_DATA, 4'b0001);
        RST_N = 1'b0;
        #1;
        check_value("t5_rst_haddr", oH_ADDR, 0);
        check_value("t5_rst_data",  oLINE_DATA, 0);
        check_value("t5_rst_dark",  oDARK_COUNT, 0);
        check_value("t5_rst_we",    oLINE_WE, 0);
        iDE = 1'b0;
        repeat (2) tick();
        RST_N = 1'b1;
        repeat (2) tick();
        wb = we_cnt; db = done_cnt;
        send_line(64'h00_00_00_00, 4, l0);
        repeat (3) tick();
        check_value("t5_no_we_without_vsync", we_cnt - wb, 0);
        vsync_pulse(vc);
        repeat (3) tick();
        send_line(64'h80_7F_F0_10, 4, l0);
        send_line(64'h80_7F_F0_10, 4, l1);
        repeat (4) tick();
        check_value("t5_we_count", we_cnt - wb, 2);
        check_value("t5_addr0",    we_addr[wb], 0);
        check_value("t5_done",     done_cnt - db, 1);
        check_value("t5_dark",     oDARK_COUNT, 4);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/video_line_capture.md
# video_line_capture

Camera-side writer for the binarized line memory that the VGA output stage reads back. Each active camera line is thresholded pixel by pixel into a one-bit-per-pixel word (1 = dark, pupil candidate) of HACTIVE bits. The completed word is written to the line memory at the line's vertical address. The block also produces per-frame dark-pixel statistics and frame-level status pulses for the eye-tracking control logic.

## Interface
Parameters:
- ADDR_WIDTH, 11, width of horizontal/vertical address and memory line address
- HACTIVE, 640, active pixels per line; width of the line word
- VACTIVE, 480, active lines per frame
- PIXEL_WIDTH, 8, camera pixel width
- COUNT_WIDTH, 20, width of the saturating per-frame dark-pixel counter

Ports (one clock, VCLK; reset RST_N is asynchronous, active-low):
- VCLK  in  1  pixel clock
- RST_N  in  1  asynchronous active-low reset
- iVSYNC  in  1  camera vertical sync, active-high
- iHSYNC  in  1  camera horizontal sync, active-high (informational; line framing uses iDE)
- iDE  in  1  camera data enable, active-high
- iPIXEL  in  PIXEL_WIDTH  camera luminance
- iTHRESHOLD  in  PIXEL_WIDTH  dark threshold; pixel is dark when iPIXEL < iTHRESHOLD
- iCAPTURE_EN  in  1  arm capture; sampled only on a frame start
- oLINE_WE  out  1  one-cycle write strobe to line memory
- oLINE_ADDR  out  ADDR_WIDTH  line index being written (0..VACTIVE-1)
- oLINE_DATA  out  HACTIVE  binarized line, bit h = pixel h
- oH_ADDR  out  ADDR_WIDTH  current captured pixel index
- oV_ADDR  out  ADDR_WIDTH  current captured line index
- oFRAME_DONE  out  1  one-cycle pulse: VACTIVE lines written
- oFRAME_ERR  out  1  one-cycle pulse: frame aborted by early VSYNC
- oOVERRUN  out  1  sticky: a line exceeded HACTIVE pixels; cleared at frame start
- oDARK_COUNT  out  COUNT_WIDTH  dark pixels of last completed frame

## Operation
- All inputs pass through one register stage; edges of VSYNC/DE are detected on the registered signals.
- States: IDLE, WAIT_LINE, ACTIVE, WRITE, DONE.
- IDLE: on VSYNC rising edge with iCAPTURE_EN=1 -> WAIT_LINE; V counter, dark accumulator, oOVERRUN cleared. With iCAPTURE_EN=0, stay in IDLE.
- WAIT_LINE: on DE rising edge -> ACTIVE; line register cleared to 0, H counter = 0.
- ACTIVE: each registered DE=1 cycle, bit[H] <= (pixel < threshold) and H increments. Dark accumulator increments and saturates at all-ones. At H = HACTIVE, further pixels are discarded and oOVERRUN is set. DE falling edge -> WRITE.
- WRITE (one cycle): oLINE_WE=1, oLINE_ADDR=V, and oLINE_DATA holds the line register. Bits of short lines that were not received stay 0. V increments. If V+1 = VACTIVE -> DONE, else -> WAIT_LINE.
- DONE (one cycle): oFRAME_DONE=1 and oDARK_COUNT latches the accumulator, then -> IDLE. DE pulses after DONE and before the next VSYNC are ignored.
- VSYNC rising edge in WAIT_LINE, ACTIVE or WRITE: an in-progress WRITE still completes its strobe. oFRAME_ERR pulses and oDARK_COUNT is not updated. The edge is then treated as a new frame start, gated by iCAPTURE_EN.
- oH_ADDR/oV_ADDR mirror the H/V counters; both are 0 in IDLE.
- Reset (any time, including mid-line): state IDLE; all outputs 0; line register and counters 0; no write strobe.

## Timing
- Pixel at input cycle t is reflected in line-register bit at cycle t+2.
- First cycle iDE is sampled low at input (cycle n): oLINE_WE high during cycle n+2, for exactly one cycle.
- oFRAME_DONE is asserted the cycle after the last oLINE_WE.
- oFRAME_ERR is asserted two cycles after iVSYNC rises at the input.
- Minimum DE-low gap between lines: 2 cycles. Shorter gaps merge the lines (not supported).

## Structure
- Shared package video_pkg: state enum encoding, HACTIVE/VACTIVE/ADDR_WIDTH defaults, and dark-compare polarity constant.
- One sub-module, sync_edge_detect: registers iVSYNC/iDE and emits rise/fall pulses. It is instantiated once per signal.
- The existing one-cycle delay primitive is reused for the iPIXEL/iTHRESHOLD input stage.

## Test plan
- 4x2 frame (HACTIVE=4, VACTIVE=2), threshold 0x80, pixels {0x10,0xF0,0x7F,0x80} on both lines -> two strobes, addr 0 then 1, data 4'b0101; oFRAME_DONE one cycle after the second strobe; oDARK_COUNT=4.
- iCAPTURE_EN=0 at VSYNC, then full frame -> no oLINE_WE, no oFRAME_DONE; oDARK_COUNT keeps its previous value.
- Line of 6 pixels with HACTIVE=4, all dark -> data 4'b1111, oOVERRUN=1 until next frame start; dark count includes only 4.
- Short line of 2 dark pixels -> data 4'b0011.
- VSYNC after line 0 of a 2-line frame -> oFRAME_ERR pulse, oDARK_COUNT unchanged; the next full frame writes addr 0 again.
- RST_N low mid-ACTIVE -> all outputs 0 immediately; after release, no strobe until the next VSYNC and DE.
